// File: rtl/eer_pkg.sv
// Shared definitions for the cluster-head advertisement parser:
// data word width, packet type codes and the parser FSM state encoding.
package eer_pkg;

  localparam int         WORD_WIDTH = 16;
  localparam logic [7:0] PKT_HB     = 8'h01;
  localparam logic [7:0] PKT_CHADV  = 8'h02;

  // state  | meaning
  // S_IDLE | waiting for a packet header word
  // S_HB   | heartbeat header seen, expecting CH limit (final word)
  // S_CHID | advertisement header seen, expecting CH ID
  // S_HOPS | expecting hop count
  // S_QV   | expecting Q-value (final word)
  // S_EMIT | complete advertisement held in shadows, publish it
  // S_DROP | malformed packet, discard words until rx_last
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HB   = 3'd1,
    S_CHID = 3'd2,
    S_HOPS = 3'd3,
    S_QV   = 3'd4,
    S_EMIT = 3'd5,
    S_DROP = 3'd6
  } state_t;

endpackage

// File: rtl/ch_adv_parser.sv
// Parses heartbeat and cluster-head advertisement packets from a word stream.
// Heartbeats publish a CH limit and clear the advertisement counter;
// advertisements publish CH ID, hops+1 (saturating) and Q-value.
//
// state  | meaning
// S_IDLE | waiting for a header word; type selects the packet path
// S_HB   | capture CH limit, which must carry rx_last
// S_CHID | capture advertised CH ID into shadow
// S_HOPS | capture hop count into shadow
// S_QV   | capture Q-value, which must carry rx_last
// S_EMIT | stall input one cycle, copy shadows to outputs unless own ID
// S_DROP | swallow words of a malformed packet until rx_last
module ch_adv_parser #(
  parameter int         WORD_WIDTH = eer_pkg::WORD_WIDTH,
  parameter logic [7:0] PKT_HB     = eer_pkg::PKT_HB,
  parameter logic [7:0] PKT_CHADV  = eer_pkg::PKT_CHADV
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] node_ID,
  input  logic                  rx_valid,
  input  logic [WORD_WIDTH-1:0] rx_data,
  input  logic                  rx_last,
  output logic                  rx_ready,
  output logic                  HB_reset,
  output logic [WORD_WIDTH-1:0] HB_CHlimit,
  output logic [WORD_WIDTH-1:0] fCH_ID,
  output logic [WORD_WIDTH-1:0] fCH_Hops,
  output logic [WORD_WIDTH-1:0] fCH_QValue,
  output logic                  en_KCH,
  output logic [7:0]            CH_count,
  output logic                  rx_err
);

  import eer_pkg::*;

  localparam logic [WORD_WIDTH-1:0] WORD_ONE  = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WORD_WIDTH-1:0] WORD_ONES = {WORD_WIDTH{1'b1}};

  state_t state, state_nx;

  logic [WORD_WIDTH-1:0] sh_id;
  logic [WORD_WIDTH-1:0] sh_hops;
  logic [WORD_WIDTH-1:0] sh_qv;
  logic [WORD_WIDTH-1:0] hops_inc;
  logic [7:0]            pkt_type;
  logic                  accept;

  logic do_err;
  logic do_hb;
  logic do_emit;
  logic cap_id;
  logic cap_hops;
  logic cap_qv;

  // The input is stalled only for the single publish cycle and during reset.
  assign rx_ready = !nrst && (state != S_EMIT);
  assign accept   = rx_valid && rx_ready;
  assign pkt_type = rx_data[WORD_WIDTH-1 -: 8];
  assign hops_inc = (sh_hops == WORD_ONES) ? WORD_ONES : sh_hops + WORD_ONE;

  // State register.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nx = state;
    do_err   = 1'b0;
    do_hb    = 1'b0;
    do_emit  = 1'b0;
    cap_id   = 1'b0;
    cap_hops = 1'b0;
    cap_qv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (pkt_type == PKT_HB || pkt_type == PKT_CHADV) begin
            // A known header that is also the last word is a truncated packet.
            if (rx_last) begin
              do_err = 1'b1;
            end else if (pkt_type == PKT_HB) begin
              state_nx = S_HB;
            end else begin
              state_nx = S_CHID;
            end
          end else begin
            do_err = 1'b1;
            if (!rx_last) begin
              state_nx = S_DROP;
            end
          end
        end
      end
      S_HB: begin
        if (accept) begin
          if (rx_last) begin
            do_hb    = 1'b1;
            state_nx = S_IDLE;
          end else begin
            do_err   = 1'b1;
            state_nx = S_DROP;
          end
        end
      end
      S_CHID: begin
        if (accept) begin
          cap_id = 1'b1;
          if (rx_last) begin
            do_err   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_HOPS;
          end
        end
      end
      S_HOPS: begin
        if (accept) begin
          cap_hops = 1'b1;
          if (rx_last) begin
            do_err   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_QV;
          end
        end
      end
      S_QV: begin
        if (accept) begin
          if (rx_last) begin
            cap_qv   = 1'b1;
            state_nx = S_EMIT;
          end else begin
            do_err   = 1'b1;
            state_nx = S_DROP;
          end
        end
      end
      S_EMIT: begin
        // Our own advertisement echoed back is ignored without error.
        do_emit  = (sh_id != node_ID);
        state_nx = S_IDLE;
      end
      S_DROP: begin
        if (accept && rx_last) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Shadow capture of advertisement fields while the packet streams in.
  always_ff @(posedge clk) begin
    if (nrst) begin
      sh_id   <= '0;
      sh_hops <= '0;
      sh_qv   <= '0;
    end else begin
      if (cap_id) begin
        sh_id <= rx_data;
      end
      if (cap_hops) begin
        sh_hops <= rx_data;
      end
      if (cap_qv) begin
        sh_qv <= rx_data;
      end
    end
  end

  // Published advertisement fields, held until the next emit.
  always_ff @(posedge clk) begin
    if (nrst) begin
      fCH_ID     <= '0;
      fCH_Hops   <= WORD_ONES;
      fCH_QValue <= '0;
    end else if (do_emit) begin
      fCH_ID     <= sh_id;
      fCH_Hops   <= hops_inc;
      fCH_QValue <= sh_qv;
    end
  end

  // Heartbeat limit and advertisement counter; a heartbeat restarts the count.
  always_ff @(posedge clk) begin
    if (nrst) begin
      HB_CHlimit <= '0;
      CH_count   <= 8'd0;
    end else if (do_hb) begin
      HB_CHlimit <= rx_data;
      CH_count   <= 8'd0;
    end else if (do_emit && CH_count != 8'hFF) begin
      CH_count <= CH_count + 8'd1;
    end
  end

  // One-cycle event pulses, registered one cycle after their trigger.
  always_ff @(posedge clk) begin
    if (nrst) begin
      HB_reset <= 1'b0;
      en_KCH   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      HB_reset <= do_hb;
      en_KCH   <= do_emit;
      rx_err   <= do_err;
    end
  end

endmodule

// File: tb/tb_ch_adv_parser.sv
// Bench for ch_adv_parser: directed packets plus randomized packet streams,
// checked against a packet-level reference model.
module tb_ch_adv_parser;

  import eer_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         nrst;
  logic [W-1:0] node_ID;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         rx_last;
  logic         rx_ready;
  logic         HB_reset;
  logic [W-1:0] HB_CHlimit;
  logic [W-1:0] fCH_ID;
  logic [W-1:0] fCH_Hops;
  logic [W-1:0] fCH_QValue;
  logic         en_KCH;
  logic [7:0]   CH_count;
  logic         rx_err;

  ch_adv_parser dut (
    .clk        (clk),
    .nrst       (nrst),
    .node_ID    (node_ID),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_last    (rx_last),
    .rx_ready   (rx_ready),
    .HB_reset   (HB_reset),
    .HB_CHlimit (HB_CHlimit),
    .fCH_ID     (fCH_ID),
    .fCH_Hops   (fCH_Hops),
    .fCH_QValue (fCH_QValue),
    .en_KCH     (en_KCH),
    .CH_count   (CH_count),
    .rx_err     (rx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // cycle counter and pulse monitor
  int cyc = 0;
  int n_err = 0;
  int n_hb = 0;
  int n_kch = 0;
  int kch_cyc = 0;
  int acc_cyc = 0;
  bit overlap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!nrst) begin
      if (rx_err) n_err <= n_err + 1;
      if (HB_reset) n_hb <= n_hb + 1;
      if (en_KCH) begin
        n_kch   <= n_kch + 1;
        kch_cyc <= cyc;
      end
      if (HB_reset && en_KCH) overlap <= 1'b1;
    end
  end

  // reference model state
  logic [W-1:0] m_fid, m_fhops, m_fqv, m_hblim;
  int           m_count;
  int           e_err, e_hb, e_kch;

  logic [W-1:0] pkt[$];
  bit           bubbles = 1'b0;
  bit           drop_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fid   = '0;
    m_fhops = 16'hFFFF;
    m_fqv   = '0;
    m_hblim = '0;
    m_count = 0;
  endtask

  // Packet-level outcome: classify by type and length only.
  task automatic model_pkt();
    logic [W-1:0] hdr;
    int n;
    hdr = pkt[0];
    n = pkt.size();
    e_err = 0; e_hb = 0; e_kch = 0;
    if (hdr[15:8] == PKT_HB) begin
      if (n == 2) begin
        e_hb = 1;
        m_hblim = pkt[1];
        m_count = 0;
      end else begin
        e_err = 1;
      end
    end else if (hdr[15:8] == PKT_CHADV) begin
      if (n == 4) begin
        if (pkt[1] != node_ID) begin
          e_kch = 1;
          m_fid = pkt[1];
          m_fhops = (pkt[2] == 16'hFFFF) ? 16'hFFFF : pkt[2] + 16'd1;
          m_fqv = pkt[3];
          if (m_count < 255) m_count++;
        end
      end else begin
        e_err = 1;
      end
    end else begin
      e_err = 1;
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic send_pkt();
    int waited;
    for (int i = 0; i < pkt.size(); i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          rx_valid = 1'b0;
          @(negedge clk);
        end
      end
      rx_valid = 1'b1;
      rx_data  = pkt[i];
      rx_last  = (i == pkt.size() - 1) && !drop_last;
      waited = 0;
      while (!rx_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
      acc_cyc = cyc;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_fid"}, fCH_ID, m_fid);
    chk({tag, "_fhops"}, fCH_Hops, m_fhops);
    chk({tag, "_fqv"}, fCH_QValue, m_fqv);
    chk({tag, "_hblim"}, HB_CHlimit, m_hblim);
    chk({tag, "_count"}, CH_count, m_count);
  endtask

  task automatic run_pkt(input string tag);
    int s_err, s_hb, s_kch;
    s_err = n_err; s_hb = n_hb; s_kch = n_kch;
    model_pkt();
    send_pkt();
    repeat (5) @(negedge clk);
    chk({tag, "_errpulses"}, n_err - s_err, e_err);
    chk({tag, "_hbpulses"}, n_hb - s_hb, e_hb);
    chk({tag, "_kchpulses"}, n_kch - s_kch, e_kch);
    if (e_kch == 1) chk({tag, "_latency"}, kch_cyc - acc_cyc, 2);
    check_outputs(tag);
  endtask

  task automatic build_random();
    int r, len;
    logic [7:0] t;
    pkt.delete();
    r = $urandom_range(0, 9);
    if (r < 3) begin
      len = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 3) : 2;
      pkt.push_back({PKT_HB, 8'($urandom)});
      for (int i = 1; i < len; i++) pkt.push_back(16'($urandom));
    end else if (r < 8) begin
      case ($urandom_range(0, 7))
        0: len = 1;
        1: len = 2;
        2: len = 3;
        3: len = 5;
        default: len = 4;
      endcase
      pkt.push_back({PKT_CHADV, 8'($urandom)});
      if (len > 1) pkt.push_back(($urandom_range(0, 4) == 0) ? node_ID : 16'($urandom));
      if (len > 2) pkt.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      for (int i = 3; i < len; i++) pkt.push_back(16'($urandom));
    end else begin
      t = 8'($urandom_range(3, 255));
      len = $urandom_range(1, 3);
      pkt.push_back({t, 8'($urandom)});
      for (int i = 1; i < len; i++) pkt.push_back(16'($urandom));
    end
  endtask

  initial begin
    int s_err;
    nrst     = 1'b1;
    node_ID  = 16'd23;
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_last  = 1'b0;
    model_reset();

    // reset values
    repeat (3) @(negedge clk);
    chk("reset_ready", rx_ready, 1'b0);
    chk("reset_hbreset", HB_reset, 1'b0);
    chk("reset_enkch", en_KCH, 1'b0);
    chk("reset_rxerr", rx_err, 1'b0);
    check_outputs("reset");
    nrst = 1'b0;
    @(negedge clk);
    chk("idle_ready", rx_ready, 1'b1);

    // heartbeat
    pkt = '{16'h0100, 16'd3};
    run_pkt("hb");
    chk("hb_limit_abs", HB_CHlimit, 16'd3);

    // basic advertisement
    pkt = '{16'h0200, 16'd23 + 16'd0, 16'd2, 16'h3000};
    node_ID = 16'd5;
    run_pkt("chadv");
    chk("chadv_hops_abs", fCH_Hops, 16'd3);
    chk("chadv_count_abs", CH_count, 8'd1);
    node_ID = 16'd23;

    // saturating hops, then own-ID drop
    pkt = '{16'h0200, 16'd40, 16'hFFFF, 16'h1234};
    run_pkt("hopsat");
    pkt = '{16'h0200, 16'd23, 16'd7, 16'h2222};
    run_pkt("ownid");

    // unknown type with trailing words, then a clean advertisement
    pkt = '{16'h0700, 16'hAAAA, 16'h5555};
    run_pkt("badtype");
    pkt = '{16'h0200, 16'd99, 16'd4, 16'h0101};
    run_pkt("after_bad");

    // truncated advertisement and a missing rx_last advertisement
    pkt = '{16'h0200, 16'd50, 16'd6};
    run_pkt("trunc");
    pkt = '{16'h0200, 16'd51, 16'd6, 16'h4000, 16'h0000};
    run_pkt("overlong");

    // reset in the middle of an advertisement
    s_err = n_err;
    pkt = '{16'h0200, 16'd77};
    drop_last = 1'b1;
    send_pkt();
    drop_last = 1'b0;
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_ready", rx_ready, 1'b0);
    model_reset();
    check_outputs("midrst");
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_noerr", n_err - s_err, 0);
    bubbles = 1'b1;
    pkt = '{16'h0200, 16'd88, 16'd9, 16'h2800};
    run_pkt("clean");

    // randomized packet stream with bubbles
    for (int k = 0; k < 80; k++) begin
      build_random();
      run_pkt($sformatf("rand%0d", k));
    end

    // counter saturation
    bubbles = 1'b0;
    pkt = '{16'h0100, 16'd9};
    run_pkt("sat_hb");
    for (int k = 0; k < 260; k++) begin
      pkt = '{16'h0200, 16'(100 + k), 16'(k), 16'h1000};
      run_pkt("sat");
    end
    chk("sat_count", CH_count, 8'hFF);

    chk("no_overlap", overlap, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
